// File: rtl/nbody_host_if.sv
// nbody_host_if
//   Register-style bus between nbody_host and the n-body accelerator.
//   Writes take effect in the strobe cycle. Read data is returned one cycle
//   after the read strobe.
//
//   Signals:
//     av_addr        host -> accel  {op[6:0], body[8:0]}
//     av_writedata   host -> accel  write data
//     av_write       host -> accel  write strobe
//     av_read        host -> accel  read strobe
//     av_chipselect  host -> accel  high with every strobe
//     av_readdata    accel -> host  read data
interface nbody_host_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] av_addr;
    logic [DATA_WIDTH-1:0] av_writedata;
    logic                  av_write;
    logic                  av_read;
    logic                  av_chipselect;
    logic [DATA_WIDTH-1:0] av_readdata;

    modport master (
        output av_addr, av_writedata, av_write, av_read, av_chipselect,
        input  av_readdata
    );

    modport slave (
        input  av_addr, av_writedata, av_write, av_read, av_chipselect,
        output av_readdata
    );
endinterface

// File: rtl/nbody_host.sv
// nbody_host
//   Host-side sequencer for the n-body accelerator. It configures the
//   accelerator and streams in the body words. It then starts the
//   accelerator, polls DONE, and streams the x/y results out for each frame.
//
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     start                 run request pulse; ignored while busy
//     n_bodies/gap/frames   run configuration, sampled on start
//     in_data/in_valid/in_ready      body words x,y,m,vx,vy per body
//     out_data/out_valid/out_ready   results x then y per body
//     out_last              y word of the last body of a frame
//     busy, done, error     run status
//     av                    accelerator bus (master side)
//
//   state   | meaning
//   --------+---------------------------------------------------
//   IDLE    | wait for start, latch config
//   CFG     | write body count, gap, clear ack
//   LOAD    | accept body words, write each to its table
//   GO      | write run = 1
//   POLL    | read status, check DONE bit
//   WAIT    | POLL_GAP cycles between polls
//   ACK     | write ack = 1
//   RDX     | read x result of current body
//   RDY     | read y result of current body
//   EMIT    | present captured word on the output stream
//   RELEASE | write ack = 0, advance frame
//   STOP    | write run = 0, pulse done
module nbody_host #(
    parameter int BODIES     = 512,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int MIN_BODIES = 21,
    parameter int POLL_GAP   = 16,
    parameter int POLL_LIMIT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8:0]            n_bodies,
    input  logic [8:0]            gap,
    input  logic [15:0]           frames,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    nbody_host_if.master          av
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CFG     = 4'd1;
    localparam logic [3:0] S_LOAD    = 4'd2;
    localparam logic [3:0] S_GO      = 4'd3;
    localparam logic [3:0] S_POLL    = 4'd4;
    localparam logic [3:0] S_WAIT    = 4'd5;
    localparam logic [3:0] S_ACK     = 4'd6;
    localparam logic [3:0] S_RDX     = 4'd7;
    localparam logic [3:0] S_RDY     = 4'd8;
    localparam logic [3:0] S_EMIT    = 4'd9;
    localparam logic [3:0] S_RELEASE = 4'd10;
    localparam logic [3:0] S_STOP    = 4'd11;

    localparam logic [6:0] OP_CTRL   = 7'h00;
    localparam logic [6:0] OP_ACK    = 7'h01;
    localparam logic [6:0] OP_NB     = 7'h02;
    localparam logic [6:0] OP_BODY0  = 7'h03;
    localparam logic [6:0] OP_GAP    = 7'h08;
    localparam logic [6:0] OP_STATUS = 7'h40;
    localparam logic [6:0] OP_RX     = 7'h41;
    localparam logic [6:0] OP_RY     = 7'h42;

    localparam logic [15:0] GAP_LOAD  = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

    logic [3:0]            state_q, state_d;
    logic [1:0]            ph_q, ph_d;
    logic [2:0]            k_q, k_d;
    logic [8:0]            body_q, body_d;
    logic [8:0]            n_q, n_d;
    logic [8:0]            gap_q, gap_d;
    logic [15:0]           frames_q, frames_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [15:0]           poll_cnt_q, poll_cnt_d;
    logic [15:0]           wait_q, wait_d;
    logic                  emit_y_q, emit_y_d;
    logic [ADDR_WIDTH-1:0] av_addr_q, av_addr_d;
    logic [DATA_WIDTH-1:0] av_wdata_q, av_wdata_d;
    logic                  av_write_q, av_write_d;
    logic                  av_read_q, av_read_d;
    logic                  av_cs_q, av_cs_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [15:0]           rd_addr;
    logic                  rd_done;
    logic                  bad_count;
    logic                  last_body;

    assign bad_count = ({23'd0, n_bodies} < 32'(MIN_BODIES)) ||
                       ({23'd0, n_bodies} > 32'(BODIES));
    assign last_body = (body_q == n_q - 9'd1);

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        k_d         = k_q;
        body_d      = body_q;
        n_d         = n_q;
        gap_d       = gap_q;
        frames_d    = frames_q;
        frame_cnt_d = frame_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        wait_d      = wait_q;
        emit_y_d    = emit_y_q;
        av_addr_d   = av_addr_q;
        av_wdata_d  = av_wdata_q;
        av_write_d  = 1'b0;
        av_read_d   = 1'b0;
        av_cs_d     = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        rd_done     = 1'b0;

        case (state_q)
            S_RDX:   rd_addr = {OP_RX, body_q};
            S_RDY:   rd_addr = {OP_RY, body_q};
            default: rd_addr = {OP_STATUS, 9'd0};
        endcase

        // Shared read sequence: address alone, then strobe, then one cycle of
        // latency; read data is valid in phase 3.
        if (state_q == S_POLL || state_q == S_RDX || state_q == S_RDY) begin
            case (ph_q)
                2'd0: begin
                    av_addr_d = ADDR_WIDTH'(rd_addr);
                    ph_d      = 2'd1;
                end
                2'd1: begin
                    av_read_d = 1'b1;
                    av_cs_d   = 1'b1;
                    ph_d      = 2'd2;
                end
                2'd2: ph_d = 2'd3;
                default: begin
                    rd_done = 1'b1;
                    ph_d    = 2'd0;
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d         = n_bodies;
                    gap_d       = gap;
                    frames_d    = (frames == 16'd0) ? 16'd1 : frames;
                    frame_cnt_d = 16'd0;
                    body_d      = 9'd0;
                    k_d         = 3'd0;
                    ph_d        = 2'd0;
                    if (bad_count) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_CFG;
                    end
                end
            end
            S_CFG: begin
                av_write_d = 1'b1;
                av_cs_d    = 1'b1;
                case (ph_q)
                    2'd0: begin
                        av_addr_d  = ADDR_WIDTH'({OP_NB, 9'd0});
                        av_wdata_d = DATA_WIDTH'(n_q);
                    end
                    2'd1: begin
                        av_addr_d  = ADDR_WIDTH'({OP_GAP, 9'd0});
                        av_wdata_d = DATA_WIDTH'(gap_q);
                    end
                    default: begin
                        av_addr_d  = ADDR_WIDTH'({OP_ACK, 9'd0});
                        av_wdata_d = '0;
                    end
                endcase
                if (ph_q == 2'd2) begin
                    ph_d    = 2'd0;
                    state_d = S_LOAD;
                end else begin
                    ph_d = ph_q + 2'd1;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    av_write_d = 1'b1;
                    av_cs_d    = 1'b1;
                    av_addr_d  = ADDR_WIDTH'({OP_BODY0 + 7'(k_q), body_q});
                    av_wdata_d = in_data;
                    if (k_q == 3'd4) begin
                        k_d = 3'd0;
                        if (last_body) begin
                            body_d  = 9'd0;
                            state_d = S_GO;
                        end else begin
                            body_d = body_q + 9'd1;
                        end
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            S_GO: begin
                av_write_d = 1'b1;
                av_cs_d    = 1'b1;
                av_addr_d  = ADDR_WIDTH'({OP_CTRL, 9'd0});
                av_wdata_d = DATA_WIDTH'(1);
                poll_cnt_d = 16'd0;
                ph_d       = 2'd0;
                state_d    = S_POLL;
            end
            S_POLL: begin
                if (rd_done) begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                    if (av.av_readdata[0]) begin
                        state_d = S_ACK;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        error_d = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        wait_d  = GAP_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 16'd0) begin
                    state_d = S_POLL;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            S_ACK: begin
                av_write_d = 1'b1;
                av_cs_d    = 1'b1;
                av_addr_d  = ADDR_WIDTH'({OP_ACK, 9'd0});
                av_wdata_d = DATA_WIDTH'(1);
                body_d     = 9'd0;
                state_d    = S_RDX;
            end
            S_RDX, S_RDY: begin
                if (rd_done) begin
                    out_data_d  = av.av_readdata;
                    out_valid_d = 1'b1;
                    out_last_d  = (state_q == S_RDY) && last_body;
                    emit_y_d    = (state_q == S_RDY);
                    state_d     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (!emit_y_q) begin
                        state_d = S_RDY;
                    end else if (last_body) begin
                        body_d  = 9'd0;
                        state_d = S_RELEASE;
                    end else begin
                        body_d  = body_q + 9'd1;
                        state_d = S_RDX;
                    end
                end
            end
            S_RELEASE: begin
                av_write_d  = 1'b1;
                av_cs_d     = 1'b1;
                av_addr_d   = ADDR_WIDTH'({OP_ACK, 9'd0});
                av_wdata_d  = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
                // The accelerator restarts itself once ack drops, so later
                // frames go straight back to polling without a new run write.
                if ({1'b0, frame_cnt_q} + 17'd1 < {1'b0, frames_q}) begin
                    poll_cnt_d = 16'd0;
                    ph_d       = 2'd0;
                    state_d    = S_POLL;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                av_write_d = 1'b1;
                av_cs_d    = 1'b1;
                av_addr_d  = ADDR_WIDTH'({OP_CTRL, 9'd0});
                av_wdata_d = '0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            k_q         <= '0;
            body_q      <= '0;
            n_q         <= '0;
            gap_q       <= '0;
            frames_q    <= '0;
            frame_cnt_q <= '0;
            poll_cnt_q  <= '0;
            wait_q      <= '0;
            emit_y_q    <= 1'b0;
            av_addr_q   <= '0;
            av_wdata_q  <= '0;
            av_write_q  <= 1'b0;
            av_read_q   <= 1'b0;
            av_cs_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            k_q         <= k_d;
            body_q      <= body_d;
            n_q         <= n_d;
            gap_q       <= gap_d;
            frames_q    <= frames_d;
            frame_cnt_q <= frame_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            wait_q      <= wait_d;
            emit_y_q    <= emit_y_d;
            av_addr_q   <= av_addr_d;
            av_wdata_q  <= av_wdata_d;
            av_write_q  <= av_write_d;
            av_read_q   <= av_read_d;
            av_cs_q     <= av_cs_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready         = (state_q == S_LOAD);
    assign out_data         = out_data_q;
    assign out_valid        = out_valid_q;
    assign out_last         = out_last_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign av.av_addr       = av_addr_q;
    assign av.av_writedata  = av_wdata_q;
    assign av.av_write      = av_write_q;
    assign av.av_read       = av_read_q;
    assign av.av_chipselect = av_cs_q;

endmodule

// File: tb/tb_nbody_host.sv
module tb_nbody_host;
    localparam int PL   = 4;
    localparam int PG   = 16;
    localparam int MINB = 21;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [8:0]  n_bodies, gap;
    logic [15:0] frames;
    logic [63:0] in_data;
    logic        in_valid, in_ready;
    logic [63:0] out_data;
    logic        out_valid, out_ready, out_last;
    logic        busy, done, error;

    nbody_host_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) av_bus ();

    nbody_host #(
        .BODIES(512), .DATA_WIDTH(64), .ADDR_WIDTH(16),
        .MIN_BODIES(MINB), .POLL_GAP(PG), .POLL_LIMIT(PL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_bodies(n_bodies), .gap(gap),
        .frames(frames), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .error(error), .av(av_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [15:0] addr;
        logic [63:0] data;
    } bus_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    bus_t        exp_bus[$];
    logic [64:0] exp_out[$];
    logic [63:0] in_q[$];
    int          acc_zero[$];
    bit          acc_never = 0;
    int          acc_frame = 0;
    logic [31:0] run_seed = 32'h1234_5678;
    bit          stall_req = 0;
    int          stall_cnt = 0;
    int          cs_count = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Accelerator result contents: arbitrary but unique per (axis, frame, body).
    function automatic logic [63:0] res_word(input bit y, input int f, input int b);
        return {run_seed ^ (y ? 32'h5A5A_A5A5 : 32'h0), 16'(f), 16'(b)};
    endfunction

    task automatic push_w(input logic [15:0] a, input logic [63:0] d);
        bus_t e;
        e.rd = 1'b0; e.addr = a; e.data = d;
        exp_bus.push_back(e);
    endtask

    task automatic push_r(input logic [15:0] a);
        bus_t e;
        e.rd = 1'b1; e.addr = a; e.data = '0;
        exp_bus.push_back(e);
    endtask

    // Body word source
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            if (in_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = in_q[0];
                if (in_ready) void'(in_q.pop_front());
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
            end
        end
    end

    // Result sink with optional 10-cycle stall
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else if (stall_req && out_valid) begin
                stall_req = 0;
                stall_cnt = 9;
                out_ready = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Accelerator model: DONE after a chosen number of not-done polls per frame
    initial begin
        logic [15:0] a;
        logic [63:0] d;
        av_bus.av_readdata = '0;
        forever begin
            @(negedge clk);
            if (av_bus.av_read && av_bus.av_chipselect) begin
                a = av_bus.av_addr;
                case (a[15:9])
                    7'h40: begin
                        d = {$urandom, $urandom};
                        d[0] = 1'b0;
                        if (!acc_never && acc_zero.size() > 0) begin
                            if (acc_zero[0] > 0) acc_zero[0] = acc_zero[0] - 1;
                            else begin
                                d[0] = 1'b1;
                                void'(acc_zero.pop_front());
                                acc_frame++;
                            end
                        end
                    end
                    7'h41:   d = res_word(1'b0, acc_frame - 1, int'(a[8:0]));
                    7'h42:   d = res_word(1'b1, acc_frame - 1, int'(a[8:0]));
                    default: d = {$urandom, $urandom};
                endcase
                av_bus.av_readdata = d;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [15:0] prev_addr = '0;
        logic        prev_cs = 1'b0;
        bit          prev_stall = 0;
        logic [63:0] prev_od = '0;
        logic        prev_ol = 1'b0;
        bit          poll_seen = 0;
        int          idle = 0;
        bus_t        e;
        logic [64:0] eo;
        logic        cs, wr, rd;
        logic [15:0] addr;
        forever begin
            @(negedge clk);
            #1;
            cs = av_bus.av_chipselect; wr = av_bus.av_write; rd = av_bus.av_read;
            addr = av_bus.av_addr;
            if (cs || wr || rd) begin
                cs_count++;
                chk("bus_cs", 64'(cs), 64'd1);
                chk("bus_strobe", 64'(wr) + 64'(rd), 64'd1);
                if (rd) begin
                    chk("rd_addr_setup", 64'(prev_addr), 64'(addr));
                    chk("rd_setup_idle", 64'(prev_cs), 64'd0);
                end
                if (exp_bus.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL bus_extra: got rd=%0b addr=%h, expected no access at %0t", rd, addr, $time);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_kind", 64'(rd), 64'(e.rd));
                    chk("bus_addr", 64'(addr), 64'(e.addr));
                    if (!e.rd) chk("bus_wdata", av_bus.av_writedata, e.data);
                end
                if (rd && addr == 16'h8000) begin
                    if (poll_seen) begin
                        n_cmp++;
                        if (idle < PG || idle > PG + 4) begin
                            n_bad++;
                            $display("FAIL poll_gap: got %0d idle cycles, expected %0d..%0d", idle, PG, PG + 4);
                        end
                    end
                    poll_seen = 1;
                    idle = 0;
                end else begin
                    poll_seen = 0;
                end
            end else if (poll_seen) begin
                idle++;
            end
            if (prev_stall) begin
                chk("stall_data", out_data, prev_od);
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_last", 64'(out_last), 64'(prev_ol));
                chk("stall_bus", 64'(cs), 64'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL out_extra: got %h, expected no output at %0t", out_data, $time);
                end else begin
                    eo = exp_out.pop_front();
                    chk("out_data", out_data, eo[63:0]);
                    chk("out_last", 64'(out_last), 64'(eo[64]));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_od = out_data; prev_ol = out_last;
            prev_addr = addr; prev_cs = cs;
        end
    end

    // Reference model: the whole bus/output story of a run, computed up front.
    task automatic build(input int n, input int gp, input int fr, input int zmin,
                         input int zmax, input bit never);
        int nf;
        int z;
        logic [63:0] w;
        nf = (fr == 0) ? 1 : fr;
        exp_bus.delete(); exp_out.delete(); in_q.delete(); acc_zero.delete();
        acc_never = never; acc_frame = 0; run_seed = $urandom; cs_count = 0;
        if (n < MINB) return;
        push_w(16'h0400, 64'(n));
        push_w(16'h1000, 64'(gp));
        push_w(16'h0200, 64'd0);
        for (int b = 0; b < n; b++)
            for (int k = 0; k < 5; k++) begin
                w = {$urandom, $urandom};
                in_q.push_back(w);
                push_w({7'(3 + k), 9'(b)}, w);
            end
        push_w(16'h0000, 64'd1);
        if (never) begin
            repeat (PL) push_r(16'h8000);
        end else begin
            for (int f = 0; f < nf; f++) begin
                z = $urandom_range(zmin, zmax);
                acc_zero.push_back(z);
                repeat (z + 1) push_r(16'h8000);
                push_w(16'h0200, 64'd1);
                for (int b = 0; b < n; b++) begin
                    push_r({7'h41, 9'(b)});
                    push_r({7'h42, 9'(b)});
                    exp_out.push_back({1'b0, res_word(1'b0, f, b)});
                    exp_out.push_back({(b == n - 1), res_word(1'b1, f, b)});
                end
                push_w(16'h0200, 64'd0);
            end
        end
        push_w(16'h0000, 64'd0);
    endtask

    task automatic pulse_start(input int n, input int gp, input int fr);
        @(negedge clk);
        n_bodies = 9'(n); gap = 9'(gp); frames = 16'(fr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_bodies = 9'($urandom); gap = 9'($urandom); frames = 16'($urandom);
    endtask

    task automatic run(input int n, input int gp, input int fr, input int zmin,
                       input int zmax, input bit never, input bit stall, input bit poke);
        bit bad, exp_err, got;
        bad = (n < MINB);
        exp_err = bad || never;
        build(n, gp, fr, zmin, zmax, never);
        stall_req = stall;
        pulse_start(n, gp, fr);
        chk("busy_after_start", 64'(busy), 64'(!bad));
        got = 0;
        for (int c = 0; c < 6000; c++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (poke && c == 60) begin
                start = 1'b1; n_bodies = 9'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 64'(got), 64'd1);
        chk("error_at_done", 64'(error), 64'(exp_err));
        chk("busy_at_done", 64'(busy), 64'd0);
        #2;
        chk("exp_bus_drained", 64'(exp_bus.size()), 64'd0);
        chk("exp_out_drained", 64'(exp_out.size()), 64'd0);
        chk("in_drained", 64'(in_q.size()), 64'd0);
        if (bad) chk("no_bus_on_bad_count", 64'(cs_count), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("error_sticky", 64'(error), 64'(exp_err));
        stall_req = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_av_write"}, 64'(av_bus.av_write), 64'd0);
        chk({tag, "_av_read"}, 64'(av_bus.av_read), 64'd0);
        chk({tag, "_av_cs"}, 64'(av_bus.av_chipselect), 64'd0);
        chk({tag, "_av_addr"}, 64'(av_bus.av_addr), 64'd0);
        chk({tag, "_av_wdata"}, av_bus.av_writedata, 64'd0);
    endtask

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; n_bodies = '0; gap = '0; frames = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        run(3, 0, 1, 0, 0, 0, 0, 0);
        run(MINB - 1, 7, 1, 0, 0, 0, 0, 0);
        run(MINB, 0, 1, 2, 2, 0, 0, 0);
        run(MINB, 5, 2, 0, 3, 0, 1, 1);
        run(MINB, 0, 1, 0, 0, 1, 0, 0);
        run(22, 3, 0, 1, 3, 0, 0, 0);

        // Reset in the middle of loading
        build(MINB, 1, 1, 0, 0, 0);
        pulse_start(MINB, 1, 1);
        waited = 0;
        while (in_q.size() > 60 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("load_progress", 64'(waited < 2000), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_av_write", 64'(av_bus.av_write), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        exp_bus.delete(); exp_out.delete(); in_q.delete(); acc_zero.delete();
        rst = 1'b0;
        #2;
        check_idle_outputs("midrst");
        run(MINB, 2, 1, 0, 1, 0, 0, 0);

        for (int i = 0; i < 4; i++)
            run($urandom_range(MINB, 40), $urandom_range(0, 511), $urandom_range(0, 2),
                0, 3, 0, ($urandom_range(0, 1) == 1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
